// File: rtl/fabric_tag_pkg.sv
// fabric_tag_pkg: constants and tag-wrap helper shared by the
// add_tag and del_tag fabric stages.
package fabric_tag_pkg;

  localparam int FABRIC_DATA_WIDTH = 32;
  localparam int FABRIC_TAG_WIDTH  = 4;

  // Advance a tag modulo num_tags. The compare runs wider than any
  // tag, so a full 2^TAG_WIDTH modulus wraps without overflow, and an
  // out-of-range current value falls back to 0 on its next advance.
  function automatic logic [31:0] next_tag(
    input logic [31:0] cur,
    input logic [31:0] num_tags
  );
    logic [31:0] inc;
    inc = cur + 32'd1;
    return (inc < num_tags) ? inc : 32'd0;
  endfunction

endpackage

// File: rtl/fabric_sync_fifo.sv
// fabric_sync_fifo: synchronous FIFO, power-of-two DEPTH.
// Ports: clk, rst (sync high), push, pop, wr_data, rd_data (head), count.
module fabric_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Caller only pushes when not full and pops when not empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (!push && pop)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fabric_add_tag.sv
// fabric_add_tag: stamps accepted tokens with a wrapping tag and
// buffers {tag, data} in an output FIFO. Optional stats counters
// (stat_accepted, stat_stall) under FABRIC_ADD_TAG_STATS_EN.
// Ports: clk, rst, in_valid/in_ready/in_data, tag_base, tag_restart,
// out_valid/out_ready/out_data, occupancy.
module fabric_add_tag
  import fabric_tag_pkg::*;
#(
  parameter int DATA_WIDTH = FABRIC_DATA_WIDTH,
  parameter int TAG_WIDTH  = FABRIC_TAG_WIDTH,
  parameter int NUM_TAGS   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [TAG_WIDTH-1:0]          tag_base,
  input  logic                          tag_restart,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH):0]        occupancy
`ifdef FABRIC_ADD_TAG_STATS_EN
  ,
  output logic [31:0]                   stat_accepted,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [TAG_WIDTH-1:0] tag_cnt;
  logic                 accept;
  logic                 pop;

  // Ready depends only on occupancy: a full FIFO stays closed
  // even while it is being popped.
  assign in_ready  = (occupancy != CW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Restart wins over advance; the token accepted alongside a
  // restart already carries the pre-restart tag.
  always_ff @(posedge clk) begin
    if (rst)
      tag_cnt <= tag_base;
    else if (tag_restart)
      tag_cnt <= tag_base;
    else if (accept)
      tag_cnt <= TAG_WIDTH'(next_tag(32'(tag_cnt), 32'(NUM_TAGS)));
  end

  fabric_sync_fifo #(
    .WIDTH (TAG_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop),
    .wr_data ({tag_cnt, in_data}),
    .rd_data (out_data),
    .count   (occupancy)
  );

`ifdef FABRIC_ADD_TAG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_stall    <= '0;
    end else begin
      if (accept && stat_accepted != 32'hFFFF_FFFF)
        stat_accepted <= stat_accepted + 32'd1;
      if (in_valid && !in_ready && stat_stall != 32'hFFFF_FFFF)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fabric_add_tag.sv
// tb_fabric_add_tag: scoreboard bench for fabric_add_tag, running a
// modulus-16 and a modulus-10 instance side by side on one stimulus.
module tb_fabric_add_tag;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  tag_base;
  logic        tag_restart;
  logic        out_ready;

  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [35:0] out_data_a, out_data_b;
  logic [2:0]  occ_a, occ_b;
`ifdef FABRIC_ADD_TAG_STATS_EN
  logic [31:0] acc_a, acc_b, stall_a, stall_b;
`endif

  fabric_add_tag dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .tag_base(tag_base), .tag_restart(tag_restart),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .occupancy(occ_a)
`ifdef FABRIC_ADD_TAG_STATS_EN
    , .stat_accepted(acc_a), .stat_stall(stall_a)
`endif
  );

  fabric_add_tag #(.NUM_TAGS(10)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .tag_base(tag_base), .tag_restart(tag_restart),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .occupancy(occ_b)
`ifdef FABRIC_ADD_TAG_STATS_EN
    , .stat_accepted(acc_b), .stat_stall(stall_b)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference model
  int          m_occ;
  int          m_tag_a, m_tag_b;
  logic [35:0] qa[$];
  logic [35:0] qb[$];
  int          m_acc, m_stall;
  bit          last_acc;

  function automatic int adv(input int t, input int m);
    if (t + 1 >= m) return 0;
    return t + 1;
  endfunction

  // Inputs change #1 after posedge; the model samples them at the
  // falling edge, checks outputs, then applies the coming posedge.
  always @(negedge clk) begin
    bit rdy;
    bit acc;
    bit pp;
    logic [3:0] ta, tb;
    if (rst) begin
      m_occ    = 0;
      qa.delete();
      qb.delete();
      m_tag_a  = int'(tag_base);
      m_tag_b  = int'(tag_base);
      m_acc    = 0;
      m_stall  = 0;
      last_acc = 0;
    end else begin
      rdy = (m_occ != 4);
      chk("in_ready_16", in_ready_a, rdy);
      chk("in_ready_10", in_ready_b, rdy);
      chk("out_valid_16", out_valid_a, m_occ != 0);
      chk("out_valid_10", out_valid_b, m_occ != 0);
      chk("occupancy_16", occ_a, m_occ);
      chk("occupancy_10", occ_b, m_occ);
`ifdef FABRIC_ADD_TAG_STATS_EN
      chk("stat_accepted", acc_a, m_acc);
      chk("stat_stall", stall_a, m_stall);
      chk("stat_accepted_10", acc_b, m_acc);
`endif
      pp = 0;
      if (m_occ != 0) begin
        chk("out_data_16", out_data_a, qa[0]);
        chk("out_data_10", out_data_b, qb[0]);
        if (out_ready) begin
          pp = 1;
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
      end
      acc = in_valid && rdy;
      if (acc) begin
        ta = m_tag_a[3:0];
        tb = m_tag_b[3:0];
        qa.push_back({ta, in_data});
        qb.push_back({tb, in_data});
        m_acc++;
      end
      if (in_valid && !rdy)
        m_stall++;
      m_occ = m_occ + int'(acc) - int'(pp);
      if (tag_restart) begin
        m_tag_a = int'(tag_base);
        m_tag_b = int'(tag_base);
      end else if (acc) begin
        m_tag_a = adv(m_tag_a, 16);
        m_tag_b = adv(m_tag_b, 10);
      end
      last_acc = acc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic rs);
    int n;
    n = 0;
    in_valid    = 1'b1;
    in_data     = d;
    tag_restart = rs;
    do begin
      @(posedge clk);
      n++;
    end while (!last_acc && n < 40);
    #1;
    in_valid    = 1'b0;
    tag_restart = 1'b0;
    if (n >= 40)
      chk("send_timeout", 0, 1);
  endtask

  task automatic restart_to(input logic [3:0] b);
    tag_base    = b;
    tag_restart = 1'b1;
    cyc(1);
    tag_restart = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    tag_base    = 4'h0;
    tag_restart = 1'b0;
    out_ready   = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // Burst of 17, checks wrap at 16 (and at 10 on dut_b)
    for (int i = 1; i <= 17; i++)
      send(32'(i), 1'b0);
    cyc(3);

    // Non-power-of-two modulus from base 8
    restart_to(4'h8);
    for (int i = 0; i < 5; i++)
      send(32'h100 + 32'(i), 1'b0);
    cyc(3);

    // Backpressure: six tokens, release after stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(32'h200 + 32'(i), 1'b0);
      end
      begin
        cyc(8);
        out_ready = 1'b1;
      end
    join
    cyc(6);

    // Full plus simultaneous pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h300 + 32'(i), 1'b0);
    out_ready = 1'b1;
    send(32'h304, 1'b0);
    send(32'h305, 1'b0);
    cyc(6);

    // Restart colliding with an accept at tag 6
    restart_to(4'h6);
    tag_base = 4'h2;
    send(32'h400, 1'b1);
    send(32'h401, 1'b0);
    send(32'h402, 1'b0);
    cyc(4);

    // Illegal base on the modulus-10 instance wraps to 0
    restart_to(4'hC);
    send(32'h500, 1'b0);
    send(32'h501, 1'b0);
    cyc(4);

    // Mid-stream reset with three entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h600 + 32'(i), 1'b0);
    tag_base = 4'h5;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("post_reset_occ", occ_a, 0);
    chk("post_reset_valid", out_valid_a, 0);
    chk("post_reset_ready", in_ready_a, 1);
    out_ready = 1'b1;
    send(32'h700, 1'b0);
    send(32'h701, 1'b0);
    cyc(5);
    chk("drained", qa.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fabric_add_tag.md
# fabric_add_tag

Upstream companion to the tag-strip stage. Accepts untagged 32-bit tokens on a valid/ready input, stamps each accepted token with a tag from a wrapping allocation counter, and buffers the tagged result in a small output FIFO. Output packing is {tag, data} with the tag in the MSBs, so the output drives a del_tag stage directly. The FIFO decouples the stamping point from downstream backpressure.

## Interface
- DATA_WIDTH, 32: payload width.
- TAG_WIDTH, 4: tag width. Must be ≥ 1.
- NUM_TAGS, 16: tag modulus. Range 1..2^TAG_WIDTH.
- DEPTH, 4: output FIFO entries. Power of two, ≥ 2.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream token valid.
- in_ready  out  1  block can accept a token this cycle.
- in_data  in  DATA_WIDTH  untagged payload.
- tag_base  in  TAG_WIDTH  tag value loaded into the counter at reset and on tag_restart.
- tag_restart  in  1  single-cycle pulse that reloads the tag counter from tag_base.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  TAG_WIDTH+DATA_WIDTH  {tag, payload}.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

## Operation
- Accept: in_valid && in_ready. Push {tag_cnt, in_data} into the FIFO, then advance tag_cnt.
- Tag advance: tag_cnt becomes tag_cnt+1 if tag_cnt+1 < NUM_TAGS, otherwise 0. Comparison uses TAG_WIDTH+1 bits, so NUM_TAGS = 2^TAG_WIDTH wraps naturally.
- tag_base ≥ NUM_TAGS is illegal. The counter loads the value unchanged, and the next advance wraps it to 0.
- tag_restart is evaluated in the same cycle as an accept:
  - The token accepted in that cycle gets the pre-restart tag.
  - The next cycle's tag_cnt = tag_base. No advance is applied in the restart cycle.
- Pop: out_valid && out_ready. The head is removed.
- in_ready = (occupancy != DEPTH). It does not depend on out_ready, so there is no combinational ready path.
- out_valid = (occupancy != 0). out_data always shows the head entry.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Allowed at any non-full occupancy, including empty. When empty, the pop is not taken because out_valid is 0, so only the push happens.
- Full: in_ready = 0 even if a pop occurs in the same cycle. The freed slot is visible on the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values (rst high at a rising edge):
  - out_valid = 0, occupancy = 0, in_ready = 1 (valid from the first cycle after reset).
  - tag_cnt = tag_base.
  - Pointers = 0.
  - out_data is don't-care.
- Reset mid-operation discards all buffered entries. No pop is signalled for them.
- Latency: a token accepted at edge N is visible on out_valid/out_data after edge N, i.e. one cycle. There is no same-cycle fall-through.
- Throughput: one token per cycle sustained while out_ready = 1.
- out_data is held stable while out_valid && !out_ready.

## Configuration
- FABRIC_ADD_TAG_STATS_EN defined:
  - Adds output stat_accepted (32 bits): the number of accepted input tokens, saturating at 32'hFFFF_FFFF.
  - Adds output stat_stall (32 bits): the number of cycles with in_valid && !in_ready, also saturating.
  - Both counters are cleared by rst. They are not cleared by tag_restart.
- FABRIC_ADD_TAG_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package fabric_tag_pkg holds:
  - Default constants FABRIC_DATA_WIDTH = 32 and FABRIC_TAG_WIDTH = 4.
  - Function next_tag(cur, num_tags), implementing the wrap rule above.
  - The same package is used by del_tag.
- Sub-module fabric_sync_fifo provides the parameterised width/depth storage, pointers and occupancy. The top level adds tag stamping, restart and stats.

## Test plan
- Reset then burst, defaults, tag_base = 4'h0, out_ready = 1:
  - Send 32'h0000_0001 to 32'h0000_0011 (17 tokens).
  - Outputs, in order: {4'h0, 32'h1} … {4'hF, 32'h10}, then {4'h0, 32'h11}. This checks wrap at 16.
  - Each token appears one cycle after its accept.
- Non-power-of-two modulus, NUM_TAGS = 10, tag_base = 4'h8:
  - Send five tokens.
  - Output tags are 8, 9, 0, 1, 2.
- Backpressure, out_ready = 0, send six tokens:
  - in_ready drops after the 4th accept and occupancy = 4.
  - out_data is held at the first token.
  - Raise out_ready: all tokens drain in order, and tokens 5 and 6 are accepted afterwards with the next tags.
- Full plus pop:
  - Setup: FIFO full, in_valid = 1, out_ready = 1.
  - Cycle 1: in_ready = 0 and no push occurs.
  - Next cycle: in_ready = 1 and occupancy = 3.
- Restart collision:
  - tag_restart pulses together with an accept at tag 4'h6, with tag_base = 4'h2.
  - That token carries tag 6, and the next token carries tag 2.
- Mid-stream reset:
  - Assert rst with occupancy = 3.
  - Next cycle: out_valid = 0, occupancy = 0, in_ready = 1.
  - The first new token carries tag_base.
  - With FABRIC_ADD_TAG_STATS_EN defined, stat_accepted = 0.
